piso_debug: RTL and testbench
=============================

Name: piso_debug

Overview:
- Debug-only parallel-in/serial-out serializer. It sits directly upstream of the debug SIPO shift register.
- It accepts one WORD_SIZE-bit internal value (for example a round-constant result) through a valid/ready handshake.
- It emits the value LSB-first as PAR-bit slices (unmasked) or (d+1)*PAR-bit slices (masked), together with the shift_en / shift_type / last_cycle controls the SIPO consumes.
- It is not on the functional datapath.

Parameters:
- WORD_SIZE, 64: width of the word to serialize.
- PAR, 4: unmasked slice width (SHIFT_PAR).
- d, 1: masking order; masked slice width SHIFT_PAR_D_PLUS_1 = (d+1)*PAR.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  word offered
- in_ready  out  1  word accepted when in_valid & in_ready
- in_mode  in  1  1 = unmasked (PAR beats), 0 = masked ((d+1)*PAR beats); sampled at accept
- in_data  in  WORD_SIZE  word to serialize
- hold  in  1  downstream stall; freezes serialization
- shift_en  out  1  slice valid this cycle
- shift_type  out  1  mode of current word (same encoding as in_mode)
- last_cycle  out  1  current slice is the final one of the word
- out_shifted_1bit  out  SHIFT_PAR  unmasked slice
- out_shifted_dplus1  out  SHIFT_PAR_D_PLUS_1  masked slice
- busy  out  1  word in flight
- word_done  out  1  one-cycle pulse, cycle after the last beat is consumed

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-high (reset). A reset mid-word discards the shadow register and returns to IDLE.
- Reset values:
  - state = IDLE, beat counter = 0, shadow = 0, mode = 1.
  - in_ready = 1, shift_en = 0, last_cycle = 0, busy = 0, word_done = 0.
  - both slice outputs = 0.
- Derived constants:
  - N1 = ceil(WORD_SIZE/PAR).
  - ND = ceil(WORD_SIZE/SHIFT_PAR_D_PLUS_1), equal to 1 when SHIFT_PAR_D_PLUS_1 >= WORD_SIZE.
  - SHIFT_PAR_LAST = WORD_SIZE - (N1-1)*PAR.
  - SHIFT_PAR_D_PLUS_1_LAST = WORD_SIZE - (ND-1)*SHIFT_PAR_D_PLUS_1, clamped to WORD_SIZE in the single-beat case.
- FSM states: IDLE, SHIFT.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch in_data into shadow, latch in_mode, clear counter, go to SHIFT.
  - No slice is emitted in the accept cycle. Latency from accept to first shift_en is 1 cycle.
- SHIFT:
  - shift_en = !hold. shift_type = latched mode.
  - The active slice output = shadow low bits (width PAR or (d+1)*PAR). The inactive slice output is driven 0.
  - On a beat (shift_en = 1): shadow shifts right by the slice width, zero-filled, and the counter increments.
  - last_cycle = 1 when counter == N-1, where N = N1 or ND by mode. It is asserted only together with shift_en.
  - On the final beat, bits above the *_LAST width are 0.
  - With hold = 1, all state and slice outputs stay frozen and shift_en = 0.
- Word completion and back-to-back:
  - On the final beat, in_ready = 1.
  - If in_valid is also high, the next word is latched and the FSM stays in SHIFT with counter = 0. This gives zero bubbles between words.
  - Otherwise the FSM goes to IDLE.
  - word_done is registered and pulses on the cycle after the final beat.
- busy = (state == SHIFT).
- in_ready = 0 in SHIFT except on an unheld final beat.
- Single-beat masked case (ND = 1): the whole word goes out in one beat with last_cycle = 1.
- Invariant: the bit ordering matches an LSB-first SIPO, so after N beats the SIPO holds in_data unchanged.

Decomposition:
- Shared ascon_params package holds:
  - SHIFT_PAR, SHIFT_PAR_D_PLUS_1, SHIFT_PAR_LAST, SHIFT_PAR_D_PLUS_1_LAST (existing).
  - Two new constants: N_BEATS_PAR and N_BEATS_D_PLUS_1.
  - A piso_state_t enum {IDLE, SHIFT}.
- Counter width = $clog2(N_BEATS_PAR), computed locally.
- No sub-module is needed. A single FSM, counter and shadow register is natural.

Test Plan:
- Unmasked serialization: WORD_SIZE=64, PAR=4, d=1; send 0x0123456789ABCDEF with in_mode=1 -> 16 beats; slices 0xF, 0xE, ..., 0x0; last_cycle only on beat 16; word_done the next cycle; the connected SIPO reads 0x0123456789ABCDEF.
- Masked serialization: same word with in_mode=0 -> 8 beats of 8 bits, 0xEF, 0xCD, ..., 0x01; out_shifted_1bit = 0 throughout; last_cycle on beat 8.
- Partial last beat: WORD_SIZE=66, PAR=4, in_data = all-ones, in_mode=1 -> 17 beats; beat 17 slice = 0x3 (upper 2 bits 0); SIPO output = all-ones.
- Hold and single-beat masked case:
  - hold=1 for 3 cycles at beat 5 -> outputs frozen, shift_en=0, total completion delayed by exactly 3 cycles.
  - With d=15, PAR=4, WORD_SIZE=64 (masked) -> single beat with last_cycle=1.
- Back-to-back words: two words with in_valid held high -> second word accepted on the first word's last beat; first beat of word 2 follows the next cycle with no gap.
- Reset mid-word: reset=1 at beat 7 -> next cycle busy=0, shift_en=0, in_ready=1. A following word serializes correctly from beat 1.

Source files
------------

// File: rtl/piso_debug_pkg.sv
// Shared serializer constants, beat-count helper and the PISO FSM state type.
// Defaults match the 64-bit word, 4-bit slice, first-order masking build.
package piso_debug_pkg;

    localparam int WORD_SIZE_DEF = 64;
    localparam int PAR_DEF       = 4;
    localparam int D_DEF         = 1;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int SHIFT_PAR               = PAR_DEF;
    localparam int SHIFT_PAR_D_PLUS_1      = (D_DEF + 1) * PAR_DEF;
    localparam int N_BEATS_PAR             = ceil_div(WORD_SIZE_DEF, SHIFT_PAR);
    localparam int N_BEATS_D_PLUS_1        = ceil_div(WORD_SIZE_DEF, SHIFT_PAR_D_PLUS_1);
    localparam int SHIFT_PAR_LAST          = WORD_SIZE_DEF - (N_BEATS_PAR - 1) * SHIFT_PAR;
    localparam int SHIFT_PAR_D_PLUS_1_LAST = (N_BEATS_D_PLUS_1 == 1) ? WORD_SIZE_DEF :
                                             WORD_SIZE_DEF - (N_BEATS_D_PLUS_1 - 1) * SHIFT_PAR_D_PLUS_1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

endpackage

// File: rtl/piso_debug.sv
// Debug PISO: emits a word LSB-first as PAR or (d+1)*PAR slices; first slice 1 cycle after accept.
// hold freezes all state and slices; a new word is accepted on the unheld final beat (no bubble).
module piso_debug
    import piso_debug_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int PAR       = PAR_DEF,
    parameter int d         = D_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic [WORD_SIZE-1:0]     in_data,
    input  logic                     hold,
    output logic                     shift_en,
    output logic                     shift_type,
    output logic                     last_cycle,
    output logic [PAR-1:0]           out_shifted_1bit,
    output logic [(d+1)*PAR-1:0]     out_shifted_dplus1,
    output logic                     busy,
    output logic                     word_done
);

    localparam int SPD = (d + 1) * PAR;
    localparam int N1  = ceil_div(WORD_SIZE, PAR);
    localparam int ND  = ceil_div(WORD_SIZE, SPD);
    // Shadow is at least one masked slice wide so a single-beat slice never reads past it.
    localparam int SW  = (WORD_SIZE > SPD) ? WORD_SIZE : SPD;
    localparam int CW  = (N1 > 1) ? $clog2(N1) : 1;
    localparam logic [CW-1:0] LAST1 = CW'(N1 - 1);
    localparam logic [CW-1:0] LASTD = CW'(ND - 1);

    piso_state_t     r_state;
    piso_state_t     w_state_nxt;
    logic [SW-1:0]   r_shadow;
    logic [CW-1:0]   r_cnt;
    logic            r_mode;
    logic            r_word_done;
    logic            w_beat;
    logic            w_last_idx;
    logic            w_accept;

    assign w_beat     = (r_state == SHIFT) && !hold;
    assign w_last_idx = r_mode ? (r_cnt == LAST1) : (r_cnt == LASTD);
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = SHIFT;
            SHIFT:   if (w_beat && w_last_idx && !in_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy               = (r_state == SHIFT);
        shift_en           = w_beat;
        shift_type         = r_mode;
        last_cycle         = w_beat && w_last_idx;
        in_ready           = (r_state == IDLE) || (w_beat && w_last_idx);
        out_shifted_1bit   = '0;
        out_shifted_dplus1 = '0;
        if (r_state == SHIFT) begin
            if (r_mode) out_shifted_1bit   = r_shadow[PAR-1:0];
            else        out_shifted_dplus1 = r_shadow[SPD-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b1;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= w_beat && w_last_idx;
            if (w_accept) begin
                r_shadow <= SW'(in_data);
                r_mode   <= in_mode;
                r_cnt    <= '0;
            end else if (w_beat) begin
                // Zero fill leaves the unused high bits of a partial final slice at 0.
                r_shadow <= r_mode ? (r_shadow >> PAR) : (r_shadow >> SPD);
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign word_done = r_word_done;

endmodule

// File: tb/tb_piso_debug.sv
// Directed bench: default build, a 66-bit partial-last-beat build and a d=15 single-beat build.
module tb_piso_debug;
    import piso_debug_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // default configuration
    logic        in_valid, in_mode, hold;
    logic [63:0] in_data;
    logic        in_ready, shift_en, shift_type, last_cycle, busy, word_done;
    logic [3:0]  s1;
    logic [7:0]  sd;

    // WORD_SIZE = 66
    logic        v66, m66, h66;
    logic [65:0] d66;
    logic        r66, en66, ty66, l66, b66, wd66;
    logic [3:0]  s1_66;
    logic [7:0]  sd_66;

    // d = 15
    logic        v15, m15, h15;
    logic [63:0] d15;
    logic        r15, en15, ty15, l15, b15, wd15;
    logic [3:0]  s1_15;
    logic [63:0] sd_15;

    piso_debug u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .hold(hold), .shift_en(shift_en), .shift_type(shift_type),
        .last_cycle(last_cycle), .out_shifted_1bit(s1), .out_shifted_dplus1(sd),
        .busy(busy), .word_done(word_done)
    );

    piso_debug #(.WORD_SIZE(66), .PAR(4), .d(1)) u_dut66 (
        .clk(clk), .reset(reset), .in_valid(v66), .in_ready(r66), .in_mode(m66),
        .in_data(d66), .hold(h66), .shift_en(en66), .shift_type(ty66),
        .last_cycle(l66), .out_shifted_1bit(s1_66), .out_shifted_dplus1(sd_66),
        .busy(b66), .word_done(wd66)
    );

    piso_debug #(.WORD_SIZE(64), .PAR(4), .d(15)) u_dut15 (
        .clk(clk), .reset(reset), .in_valid(v15), .in_ready(r15), .in_mode(m15),
        .in_data(d15), .hold(h15), .shift_en(en15), .shift_type(ty15),
        .last_cycle(l15), .out_shifted_1bit(s1_15), .out_shifted_dplus1(sd_15),
        .busy(b15), .word_done(wd15)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers one word to the default DUT, optionally holding at beat hold_at for hold_len cycles,
    // and rebuilds it through an LSB-first SIPO model.
    task automatic run_word(input logic mode, input logic [63:0] data, input int hold_at, input int hold_len);
        int n, w, beat, held, cyc;
        logic [63:0] sipo, exp_sl;
        logic [7:0]  obs_sl;
        n = mode ? N_BEATS_PAR : N_BEATS_D_PLUS_1;
        w = mode ? SHIFT_PAR : SHIFT_PAR_D_PLUS_1;
        beat = 0; held = 0; cyc = 0; sipo = '0;
        in_valid = 1'b1; in_mode = mode; in_data = data; hold = 1'b0;
        @(negedge clk);
        check("accept_ready", 128'(in_ready), 128'(1));
        check("accept_no_shift", 128'(shift_en), 128'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (beat < n && cyc < 100) begin
            hold = (beat == hold_at) && (held < hold_len);
            @(negedge clk);
            exp_sl = (data >> (w * beat)) & ((64'(1) << w) - 64'(1));
            obs_sl = mode ? 8'(s1) : sd;
            check("slice", 128'(obs_sl), 128'(exp_sl));
            check("busy", 128'(busy), 128'(1));
            check("inactive_slice_zero", mode ? 128'(sd) : 128'(s1), 128'(0));
            if (hold) begin
                check("hold_shift_en", 128'(shift_en), 128'(0));
                check("hold_last", 128'(last_cycle), 128'(0));
                check("hold_ready", 128'(in_ready), 128'(0));
                held++;
            end else begin
                check("shift_en", 128'(shift_en), 128'(1));
                check("shift_type", 128'(shift_type), 128'(mode));
                check("last_cycle", 128'(last_cycle), 128'(beat == n - 1));
                check("ready_in_shift", 128'(in_ready), 128'(beat == n - 1));
                sipo = (sipo >> w) | (64'(obs_sl) << (64 - w));
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        hold = 1'b0;
        @(negedge clk);
        check("cycles_to_done", 128'(cyc), 128'(n + hold_len));
        check("word_done", 128'(word_done), 128'(1));
        check("idle_after_word", 128'(busy), 128'(0));
        check("sipo_word", 128'(sipo), 128'(data));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] wa, wb;
        logic [65:0] acc66, exp66;
        reset = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0; hold = 1'b0;
        v66 = 1'b0; m66 = 1'b0; d66 = '0; h66 = 1'b0;
        v15 = 1'b0; m15 = 1'b0; d15 = '0; h15 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", 128'(in_ready), 128'(1));
        check("rst_shift_en", 128'(shift_en), 128'(0));
        check("rst_last", 128'(last_cycle), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(word_done), 128'(0));
        check("rst_slices", 128'({s1, sd}), 128'(0));
        check("rst_type", 128'(shift_type), 128'(1));
        @(posedge clk); #1;
        reset = 1'b0;

        // unmasked, masked, and held serialization
        run_word(1'b1, 64'h0123456789ABCDEF, -1, 0);
        run_word(1'b0, 64'h0123456789ABCDEF, -1, 0);
        run_word(1'b1, 64'hFEDCBA9876543210, 4, 3);

        // back-to-back: unmasked word A then masked word B with in_valid held high
        wa = 64'hA5A5_0F0F_1234_5678;
        wb = 64'h8877_6655_4433_2211;
        in_valid = 1'b1; in_mode = 1'b1; in_data = wa;
        @(negedge clk);
        @(posedge clk); #1;
        in_mode = 1'b0; in_data = wb;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            check("b2b_a_slice", 128'(s1), 128'((wa >> (4 * b)) & 64'hF));
            check("b2b_a_ready", 128'(in_ready), 128'(b == 15));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            check("b2b_b_shift_en", 128'(shift_en), 128'(1));
            check("b2b_b_type", 128'(shift_type), 128'(0));
            check("b2b_b_slice", 128'(sd), 128'((wb >> (8 * b)) & 64'hFF));
            check("b2b_done_pulse", 128'(word_done), 128'(b == 0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("b2b_b_done", 128'(word_done), 128'(1));
        @(posedge clk); #1;

        // reset during beat 7
        in_valid = 1'b1; in_mode = 1'b1; in_data = 64'h1111_2222_3333_4444;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            check("pre_rst_slice", 128'(s1), 128'((64'h1111_2222_3333_4444 >> (4 * b)) & 64'hF));
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_shift_en", 128'(shift_en), 128'(0));
        check("mid_rst_ready", 128'(in_ready), 128'(1));
        check("mid_rst_slice", 128'(s1), 128'(0));
        @(posedge clk); #1;
        run_word(1'b1, 64'hDEAD_BEEF_CAFE_F00D, -1, 0);

        // 66-bit word: 17 beats, last slice only 2 bits wide
        exp66 = '1;
        acc66 = '0;
        v66 = 1'b1; m66 = 1'b1; d66 = exp66;
        @(negedge clk);
        @(posedge clk); #1;
        v66 = 1'b0;
        for (int b = 0; b < 17; b++) begin
            @(negedge clk);
            check("w66_shift_en", 128'(en66), 128'(1));
            check("w66_slice", 128'(s1_66), (b == 16) ? 128'(4'h3) : 128'(4'hF));
            check("w66_last", 128'(l66), 128'(b == 16));
            acc66 = acc66 | (66'(s1_66) << (4 * b));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("w66_done", 128'(wd66), 128'(1));
        check("w66_sipo", 128'(acc66), 128'(exp66));
        @(posedge clk); #1;

        // d = 15: whole masked word in one beat
        v15 = 1'b1; m15 = 1'b0; d15 = 64'h0123456789ABCDEF;
        @(negedge clk);
        @(posedge clk); #1;
        v15 = 1'b0;
        @(negedge clk);
        check("d15_shift_en", 128'(en15), 128'(1));
        check("d15_last", 128'(l15), 128'(1));
        check("d15_slice", 128'(sd_15), 128'(64'h0123456789ABCDEF));
        check("d15_ready", 128'(r15), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("d15_done", 128'(wd15), 128'(1));
        check("d15_idle", 128'(b15), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
